// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between fetch (IF) and data (DM).
// Req-to-valid takes MEM_LATENCY+2 cycles; the losing port sees stall until its own access completes.
module mem_port_arbiter #(
   parameter int A_WIDTH     = 32,
   parameter int D_WIDTH     = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               if_req,
   input  logic [A_WIDTH-1:0] if_addr,
   output logic [D_WIDTH-1:0] if_rdata,
   output logic               if_valid,
   output logic               if_stall,
   input  logic               dm_req,
   input  logic               dm_we,
   input  logic [A_WIDTH-1:0] dm_addr,
   input  logic [D_WIDTH-1:0] dm_wdata,
   output logic [D_WIDTH-1:0] dm_rdata,
   output logic               dm_valid,
   output logic               dm_stall,
   output logic               mem_en,
   output logic               mem_we,
   output logic [A_WIDTH-1:0] mem_addr,
   output logic [D_WIDTH-1:0] mem_wdata,
   input  logic [D_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic       PORT_IF = 1'b0;
   localparam logic       PORT_DM = 1'b1;
   localparam logic [3:0] LAT     = 4'(MEM_LATENCY);

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               grant_q, grant_d;
   logic               last_grant_q, last_grant_d;
   logic               we_q, we_d;
   logic [A_WIDTH-1:0] addr_q, addr_d;
   logic [D_WIDTH-1:0] wdata_q, wdata_d;
   logic [D_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic [D_WIDTH-1:0] dm_rdata_q, dm_rdata_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         grant_q      <= PORT_IF;
         last_grant_q <= PORT_IF;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         if_rdata_q   <= if_rdata_d;
         dm_rdata_q   <= dm_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      if_rdata_d   = if_rdata_q;
      dm_rdata_d   = dm_rdata_q;
      case (state_q)
         IDLE: begin
            if (if_req || dm_req) begin
               // On a tie the port that lost last time wins, so neither can starve.
               if (if_req && dm_req) grant_d = ~last_grant_q;
               else                  grant_d = dm_req ? PORT_DM : PORT_IF;
               last_grant_d = grant_d;
               if (grant_d == PORT_DM) begin
                  addr_d  = dm_addr;
                  we_d    = dm_we;
                  wdata_d = dm_wdata;
               end else begin
                  addr_d  = if_addr;
                  we_d    = 1'b0;
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = 4'd1;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == LAT) begin
               if (!we_q) begin
                  if (grant_q == PORT_DM) dm_rdata_d = mem_rdata;
                  else                    if_rdata_d = mem_rdata;
               end
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem_en    = (state_q == ISSUE);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_valid  = (state_q == DONE) && (grant_q == PORT_IF);
   assign dm_valid  = (state_q == DONE) && (grant_q == PORT_DM);
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_stall  = if_req & ~if_valid;
   assign dm_stall  = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: an L=2 instance and an L=1 instance on a shared memory model,
// with per-port queues of expected read data and completion cycles.
module tb_mem_port_arbiter;

   localparam int LA = 2;
   localparam int LB = 1;

   typedef struct {
      logic [31:0] dat;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // instance A (MEM_LATENCY = 2)
   logic        a_if_req, a_dm_req, a_dm_we;
   logic [31:0] a_if_addr, a_dm_addr, a_dm_wdata;
   logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic        a_if_valid, a_if_stall, a_dm_valid, a_dm_stall, a_mem_en, a_mem_we;

   // instance B (MEM_LATENCY = 1)
   logic        b_if_req, b_dm_req, b_dm_we;
   logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata;
   logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic        b_if_valid, b_if_stall, b_dm_valid, b_dm_stall, b_mem_en, b_mem_we;

   mem_port_arbiter #(.A_WIDTH(32), .D_WIDTH(32), .MEM_LATENCY(LA)) u_a (
      .clk(clk), .rst_n(rst_n),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata),
      .if_valid(a_if_valid), .if_stall(a_if_stall),
      .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
      .dm_rdata(a_dm_rdata), .dm_valid(a_dm_valid), .dm_stall(a_dm_stall),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
   );

   mem_port_arbiter #(.A_WIDTH(32), .D_WIDTH(32), .MEM_LATENCY(LB)) u_b (
      .clk(clk), .rst_n(rst_n),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata),
      .if_valid(b_if_valid), .if_stall(b_if_stall),
      .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
      .dm_rdata(b_dm_rdata), .dm_valid(b_dm_valid), .dm_stall(b_dm_stall),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
   );

   // memory model: fixed contents plus one remembered write
   logic [31:0] wr_addr = 32'h0;
   logic [31:0] wr_data = 32'h0;
   logic        wr_seen = 1'b0;

   function automatic logic [31:0] rd_word(input logic [31:0] addr);
      if (wr_seen && addr == wr_addr) return wr_data;
      case (addr)
         32'h10:  return 32'h0050_0093;
         32'h20:  return 32'h1111_0000;
         32'h24:  return 32'h2222_0000;
         32'h80:  return 32'h0000_1234;
         default: return addr ^ 32'h5A5A_0000;
      endcase
   endfunction

   logic [31:0] a_pd [LA];
   logic        a_pv [LA];
   logic [31:0] b_pd [LB];
   logic        b_pv [LB];

   always @(posedge clk) begin
      if (a_mem_en && a_mem_we) begin
         wr_addr <= a_mem_addr;
         wr_data <= a_mem_wdata;
         wr_seen <= 1'b1;
      end
      a_pd[0] <= rd_word(a_mem_addr);
      a_pv[0] <= a_mem_en && !a_mem_we;
      for (int i = 1; i < LA; i++) begin
         a_pd[i] <= a_pd[i-1];
         a_pv[i] <= a_pv[i-1];
      end
      b_pd[0] <= rd_word(b_mem_addr);
      b_pv[0] <= b_mem_en && !b_mem_we;
      for (int j = 1; j < LB; j++) begin
         b_pd[j] <= b_pd[j-1];
         b_pv[j] <= b_pv[j-1];
      end
   end

   // junk outside the valid slot so an early or late capture shows up
   assign a_mem_rdata = a_pv[LA-1] ? a_pd[LA-1] : 32'hBAD0_BAD0;
   assign b_mem_rdata = b_pv[LB-1] ? b_pd[LB-1] : 32'hBAD1_BAD1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      else n_pass++;
   endtask

   task automatic at_cycle(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   exp_t q_if[$];
   exp_t q_dm[$];
   exp_t q_b[$];
   exp_t mon_e;

   always @(negedge clk) begin
      if (a_if_valid) begin
         chk("a_if_valid_expected", 64'(q_if.size() != 0), 64'd1);
         if (q_if.size() != 0) begin
            mon_e = q_if.pop_front();
            chk("a_if_rdata", 64'(a_if_rdata), 64'(mon_e.dat));
            chk("a_if_valid_cycle", 64'(cyc), 64'(mon_e.cyc));
         end
      end
      if (a_dm_valid) begin
         chk("a_dm_valid_expected", 64'(q_dm.size() != 0), 64'd1);
         if (q_dm.size() != 0) begin
            mon_e = q_dm.pop_front();
            chk("a_dm_rdata", 64'(a_dm_rdata), 64'(mon_e.dat));
            chk("a_dm_valid_cycle", 64'(cyc), 64'(mon_e.cyc));
         end
      end
      if (b_dm_valid) begin
         chk("b_dm_valid_expected", 64'(q_b.size() != 0), 64'd1);
         if (q_b.size() != 0) begin
            mon_e = q_b.pop_front();
            chk("b_dm_rdata", 64'(b_dm_rdata), 64'(mon_e.dat));
            chk("b_dm_valid_cycle", 64'(cyc), 64'(mon_e.cyc));
         end
      end
      if (b_if_valid) chk("b_if_valid_never", 64'(b_if_valid), 64'd0);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int n;
      a_if_req = 0; a_dm_req = 0; a_dm_we = 0;
      a_if_addr = 0; a_dm_addr = 0; a_dm_wdata = 0;
      b_if_req = 0; b_dm_req = 0; b_dm_we = 0;
      b_if_addr = 0; b_dm_addr = 0; b_dm_wdata = 0;

      repeat (2) @(negedge clk);
      chk("rst_mem_en",   64'(a_mem_en),   64'd0);
      chk("rst_if_valid", 64'(a_if_valid), 64'd0);
      chk("rst_mem_addr", 64'(a_mem_addr), 64'd0);
      chk("rst_if_rdata", 64'(a_if_rdata), 64'd0);
      chk("rst_dm_rdata", 64'(a_dm_rdata), 64'd0);
      chk("rst_if_stall", 64'(a_if_stall), 64'd0);
      rst_n = 1'b1;

      // single IF read; the address change mid-access must not matter
      @(posedge clk); #1;
      c0 = cyc;
      a_if_req = 1; a_if_addr = 32'h10;
      q_if.push_back('{32'h0050_0093, c0 + 4});
      for (int k = 0; k < 5; k++) begin
         at_cycle(c0 + k);
         chk("t1_if_stall", 64'(a_if_stall), 64'(k < 4));
         chk("t1_mem_en",   64'(a_mem_en),   64'(k == 1));
         if (k == 1) begin
            chk("t1_mem_addr", 64'(a_mem_addr), 64'h10);
            chk("t1_mem_we",   64'(a_mem_we),   64'd0);
         end
         if (k == 2) a_if_addr = 32'h99;
      end
      @(posedge clk); #1;
      a_if_req = 0; a_if_addr = 32'h10;

      // DM write: dm_rdata stays at its reset value
      @(posedge clk); #1;
      c0 = cyc;
      a_dm_req = 1; a_dm_we = 1; a_dm_addr = 32'h40; a_dm_wdata = 32'hDEAD_BEEF;
      q_dm.push_back('{32'h0, c0 + 4});
      for (int k = 0; k < 5; k++) begin
         at_cycle(c0 + k);
         chk("t2_mem_en",   64'(a_mem_en),   64'(k == 1));
         chk("t2_mem_we",   64'(a_mem_we),   64'(k == 1));
         chk("t2_dm_stall", 64'(a_dm_stall), 64'(k < 4));
         if (k == 1) begin
            chk("t2_mem_addr",  64'(a_mem_addr),  64'h40);
            chk("t2_mem_wdata", 64'(a_mem_wdata), 64'hDEAD_BEEF);
         end
      end
      @(posedge clk); #1;
      a_dm_req = 0; a_dm_we = 0;

      // simultaneous requests straight out of reset: DM first, then IF
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      c0 = cyc;
      a_if_req = 1; a_if_addr = 32'h10;
      a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h40;
      q_dm.push_back('{32'hDEAD_BEEF, c0 + 4});
      q_if.push_back('{32'h0050_0093, c0 + 9});
      for (int k = 0; k < 10; k++) begin
         at_cycle(c0 + k);
         chk("t3_dm_stall", 64'(a_dm_stall), 64'(k < 4));
         chk("t3_if_stall", 64'(a_if_stall), 64'(k < 9));
         if (k == 4) begin
            @(posedge clk); #1;
            a_dm_req = 0;
         end
      end
      @(posedge clk); #1;
      a_if_req = 0;

      // continuous load: grants alternate DM, IF, DM, IF, DM, IF
      @(posedge clk); #1;
      c0 = cyc;
      a_if_req = 1; a_if_addr = 32'h20;
      a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h24;
      for (int j = 0; j < 6; j++) begin
         if (j % 2 == 0) q_dm.push_back('{32'h2222_0000, c0 + 4 + 5 * j});
         else            q_if.push_back('{32'h1111_0000, c0 + 4 + 5 * j});
      end
      for (int j = 0; j < 6; j++) begin
         at_cycle(c0 + 1 + 5 * j);
         chk("t4_grant_addr", 64'(a_mem_addr), (j % 2 == 0) ? 64'h24 : 64'h20);
      end
      at_cycle(c0 + 29);
      @(posedge clk); #1;
      a_if_req = 0; a_dm_req = 0;

      // async reset during WAIT abandons the access; req held so it restarts
      @(posedge clk); #1;
      c0 = cyc;
      a_if_req = 1; a_if_addr = 32'h10;
      at_cycle(c0 + 2);
      rst_n = 1'b0;
      #1;
      chk("t5_mem_en",    64'(a_mem_en),    64'd0);
      chk("t5_if_valid",  64'(a_if_valid),  64'd0);
      chk("t5_if_rdata",  64'(a_if_rdata),  64'd0);
      chk("t5_dm_rdata",  64'(a_dm_rdata),  64'd0);
      chk("t5_mem_addr",  64'(a_mem_addr),  64'd0);
      chk("t5_mem_wdata", 64'(a_mem_wdata), 64'd0);
      chk("t5_if_stall",  64'(a_if_stall),  64'd1);
      at_cycle(c0 + 3);
      chk("t5_held_mem_en", 64'(a_mem_en), 64'd0);
      rst_n = 1'b1;
      n = cyc;
      q_if.push_back('{32'h0050_0093, n + 4});
      at_cycle(n + 1);
      chk("t5_restart_mem_en",   64'(a_mem_en),   64'd1);
      chk("t5_restart_mem_addr", 64'(a_mem_addr), 64'h10);
      at_cycle(n + 4);
      @(posedge clk); #1;
      a_if_req = 0;

      // latency-1 build: DM read
      @(posedge clk); #1;
      c0 = cyc;
      b_dm_req = 1; b_dm_addr = 32'h80;
      q_b.push_back('{32'h0000_1234, c0 + 3});
      at_cycle(c0);
      chk("t6_dm_stall", 64'(b_dm_stall), 64'd1);
      at_cycle(c0 + 1);
      chk("t6_mem_en",   64'(b_mem_en),   64'd1);
      chk("t6_mem_addr", 64'(b_mem_addr), 64'h80);
      chk("t6_mem_we",   64'(b_mem_we),   64'd0);
      at_cycle(c0 + 3);
      @(posedge clk); #1;
      b_dm_req = 0;

      repeat (4) @(negedge clk);
      chk("sb_if_drained", 64'(q_if.size()), 64'd0);
      chk("sb_dm_drained", 64'(q_dm.size()), 64'd0);
      chk("sb_b_drained",  64'(q_b.size()),  64'd0);
      chk("b_if_rdata",    64'(b_if_rdata),  64'd0);
      chk("b_mem_wdata",   64'(b_mem_wdata), 64'd0);
      chk("b_if_stall",    64'(b_if_stall),  64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
